// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Two-master arbiter in front of a single bus master port.
//   m0 = core load/store unit, m1 = UART debug loader.
// Registered grants (IDLE / OWN0 / OWN1). Ties resolve to the master that did
// not win last. Outputs are muxed combinationally from the owner. Read data
// comes back one cycle after the address and goes to whoever owned the bus
// in that address cycle.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   : an owner holding the bus while the other master waits is
//               forced off after TIMEOUT_CYCLES waiting cycles.
//   undefined : no hold counter; an owner keeps the bus as long as it requests.
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        sys_clk,
    input  logic        sys_reset,

    input  logic        m0_req_i,
    input  logic        m0_wr_en_i,
    input  logic [31:0] m0_wr_addr_i,
    input  logic [31:0] m0_wr_data_i,
    input  logic [31:0] m0_rd_addr_i,
    output logic [31:0] m0_rd_data_o,

    input  logic        m1_req_i,
    input  logic        m1_wr_en_i,
    input  logic [31:0] m1_wr_addr_i,
    input  logic [31:0] m1_wr_data_i,
    input  logic [31:0] m1_rd_addr_i,
    output logic [31:0] m1_rd_data_o,

    output logic        m0_gnt_o,
    output logic        m1_gnt_o,
    output logic        m0_stall_o,

    output logic        b_wr_en_o,
    output logic [31:0] b_wr_addr_o,
    output logic [31:0] b_wr_data_o,
    output logic [31:0] b_rd_addr_o,
    input  logic [31:0] b_rd_data_i
);

    // State encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // last_gnt encoding: which master entered ownership most recently
    localparam logic LAST_M0 = 1'b0;
    localparam logic LAST_M1 = 1'b1;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_last_gnt;
    // One-hot read owner: bit0 = m0, bit1 = m1, 2'b00 = nobody
    logic [1:0]  r_rd_owner;
    logic        w_timeout;

    // Per-master views so the data path can be built uniformly
    logic [1:0]  w_gnt;
    logic [1:0]  w_wr_en;
    logic [31:0] w_wr_addr [2];
    logic [31:0] w_wr_data [2];
    logic [31:0] w_rd_addr [2];
    logic [31:0] w_rd_data [2];
    logic [1:0]  w_wr_en_sel;
    logic [31:0] w_wr_addr_sel [2];
    logic [31:0] w_wr_data_sel [2];
    logic [31:0] w_rd_addr_sel [2];

    assign w_wr_en[0]   = m0_wr_en_i;
    assign w_wr_en[1]   = m1_wr_en_i;
    assign w_wr_addr[0] = m0_wr_addr_i;
    assign w_wr_addr[1] = m1_wr_addr_i;
    assign w_wr_data[0] = m0_wr_data_i;
    assign w_wr_data[1] = m1_wr_data_i;
    assign w_rd_addr[0] = m0_rd_addr_i;
    assign w_rd_addr[1] = m1_rd_addr_i;

    // Grants decode straight from the state register, so they are one-hot or zero
    assign w_gnt[0] = (r_state == ST_OWN0);
    assign w_gnt[1] = (r_state == ST_OWN1);

    assign m0_gnt_o   = w_gnt[0];
    assign m1_gnt_o   = w_gnt[1];
    assign m0_stall_o = m0_req_i & ~w_gnt[0];

`ifdef BUS_TIMEOUT_EN
    // Hold counter: number of consecutive cycles the current owner has kept the
    // bus while the other master was requesting.
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_hold_cnt;
    logic             w_other_req;

    assign w_other_req = ((r_state == ST_OWN0) && m1_req_i) ||
                         ((r_state == ST_OWN1) && m0_req_i);

    // The current waiting cycle is number r_hold_cnt+1; once that reaches the
    // limit the owner is pushed off at the next edge.
    assign w_timeout = w_other_req && ((int'(r_hold_cnt) + 1) >= TIMEOUT_CYCLES);

    // Count waiting cycles; restart whenever ownership moves or nobody waits
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            r_hold_cnt <= '0;
        end else if ((w_state_next != r_state) || !w_other_req) begin
            r_hold_cnt <= '0;
        end else if (r_hold_cnt != {CNT_W{1'b1}}) begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
        end
    end
`else
    // No forced hand-over: an owner keeps the bus while it requests
    assign w_timeout = 1'b0;
`endif

    // Next-state decision for the ownership FSM
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m0_req_i && m1_req_i) begin
                    // Tie: favour whoever did not win last time
                    w_state_next = (r_last_gnt == LAST_M1) ? ST_OWN0 : ST_OWN1;
                end else if (m0_req_i) begin
                    w_state_next = ST_OWN0;
                end else if (m1_req_i) begin
                    w_state_next = ST_OWN1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (!m0_req_i) begin
                    // Hand straight over without an idle bubble if m1 is waiting
                    w_state_next = m1_req_i ? ST_OWN1 : ST_IDLE;
                end else if (w_timeout) begin
                    w_state_next = ST_OWN1;
                end
            end
            ST_OWN1: begin
                if (!m1_req_i) begin
                    w_state_next = m0_req_i ? ST_OWN0 : ST_IDLE;
                end else if (w_timeout) begin
                    w_state_next = ST_OWN0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Ownership state register
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Remember the most recent master to enter ownership (m1 after reset so m0
    // wins the first tie)
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            r_last_gnt <= LAST_M1;
        end else if ((w_state_next == ST_OWN0) && (r_state != ST_OWN0)) begin
            r_last_gnt <= LAST_M0;
        end else if ((w_state_next == ST_OWN1) && (r_state != ST_OWN1)) begin
            r_last_gnt <= LAST_M1;
        end
    end

    // Track who issued the read address this cycle; its data returns next cycle
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            r_rd_owner <= 2'b00;
        end else begin
            r_rd_owner <= w_gnt;
        end
    end

    // Per-master gating of the bus request fields and return-data steering.
    // Since at most one grant is high, OR-ing the gated fields is a clean mux
    // and yields all zeros when the bus is idle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign w_wr_en_sel[gi]   = w_wr_en[gi] & w_gnt[gi];
            assign w_wr_addr_sel[gi] = w_wr_addr[gi] & {32{w_gnt[gi]}};
            assign w_wr_data_sel[gi] = w_wr_data[gi] & {32{w_gnt[gi]}};
            assign w_rd_addr_sel[gi] = w_rd_addr[gi] & {32{w_gnt[gi]}};
            assign w_rd_data[gi]     = b_rd_data_i & {32{r_rd_owner[gi]}};
        end
    endgenerate

    assign b_wr_en_o   = |w_wr_en_sel;
    assign b_wr_addr_o = w_wr_addr_sel[0] | w_wr_addr_sel[1];
    assign b_wr_data_o = w_wr_data_sel[0] | w_wr_data_sel[1];
    assign b_rd_addr_o = w_rd_addr_sel[0] | w_rd_addr_sel[1];

    assign m0_rd_data_o = w_rd_data[0];
    assign m1_rd_data_o = w_rd_data[1];

endmodule
